// File: rtl/soc_system_entrada_0.sv
// soc_system_entrada_0: Avalon-MM input PIO with synchronizer, sticky edge capture and masked level irq
module soc_system_entrada_0 #(
    parameter int WIDTH     = 10,
    parameter int EDGE_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d, edge_w, clr_w;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en, unused_ok;

    assign wr_en     = chipselect & ~write_n;
    assign unused_ok = &{1'b0, writedata};
    assign edge_w    = (EDGE_TYPE == 0) ? (sync2_q & ~prev_q) :
                       (EDGE_TYPE == 1) ? (~sync2_q & prev_q) : (sync2_q ^ prev_q);
    assign clr_w     = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign irq       = |(cap_q & mask_q);
    assign readdata  = readdata_q;

    // next-state for mask, sticky capture (set beats clear) and the read mux
    always_comb begin
        mask_d     = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        cap_d      = (cap_q & ~clr_w) | edge_w;
        readdata_d = (address == 2'd0) ? 32'(sync2_q) :
                     (address == 2'd2) ? 32'(mask_q)  :
                     (address == 2'd3) ? 32'(cap_q)   : '0;
    end

    // synchronizer chain, registers and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end
endmodule
